// File: rtl/lcd_bus_cycle_pkg.sv
// Shared HD44780 definitions: bus-cycle state encoding, R/W codes and timing limits.
// The command sequencer imports this package as well.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EHIGH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } lcd_state_e;

    localparam logic LCD_WR       = 1'b0;
    localparam logic LCD_RD       = 1'b1;
    localparam int   LCD_BUSY_BIT = 7;
    localparam int   T_MAX        = 15;

    // A timing parameter must fit the 4-bit tick counter and be non-zero.
    function automatic bit t_legal(int t);
        return (t >= 1) && (t <= T_MAX);
    endfunction

endpackage

// File: rtl/lcd_bus_cycle_if.sv
// Request/response channel between the LCD command sequencer (master)
// and the bus-cycle engine (slave).
interface lcd_bus_cycle_if;
    logic       start;
    logic       rs_in;
    logic       rw_in;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;

    modport master (output start, rs_in, rw_in, data_in,
                    input  busy, done, rd_data);
    modport slave  (input  start, rs_in, rw_in, data_in,
                    output busy, done, rd_data);
endinterface

// File: rtl/lcd_tick_cnt.sv
// Loadable 4-bit down-counter timing the SETUP/EHIGH/HOLD phases.
// Loading N makes 'expired' true on the Nth cycle after the load edge.
module lcd_tick_cnt (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] value,
    output logic       expired
);
    logic [3:0] cnt_q;

    // Count down to 1 and park there; a load always wins.
    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset)             cnt_q <= 4'd0;
        else if (load)          cnt_q <= value;
        else if (cnt_q > 4'd1)  cnt_q <= cnt_q - 4'd1;
    end

    assign expired = (cnt_q == 4'd1);
endmodule

// File: rtl/lcd_bus_cycle.sv
// HD44780 bus-cycle engine: one write or read per start request, 8-bit or
// 4-bit (high nibble first) pin interface, programmable setup/E-high/hold.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int DB_W    = 8,
    parameter int T_SETUP = 1,
    parameter int T_EHIGH = 2,
    parameter int T_HOLD  = 1
) (
    input  logic            clk_1ms,
    input  logic            reset,
    lcd_bus_cycle_if.slave  bus,
    output logic            E_out,
    output logic            RS_out,
    output logic            RW_out,
    output logic [DB_W-1:0] db_out,
    output logic            db_oe,
    input  logic [DB_W-1:0] db_in
);
    if (!(DB_W == 4 || DB_W == 8)) begin : g_bad_dbw
        $error("lcd_bus_cycle: DB_W must be 4 or 8");
    end
    if (!t_legal(T_SETUP) || !t_legal(T_EHIGH) || !t_legal(T_HOLD)) begin : g_bad_t
        $error("lcd_bus_cycle: T_SETUP/T_EHIGH/T_HOLD must be in 1..15");
    end

    lcd_state_e      state_q;
    logic            nib_q;
    logic            busy_q;
    logic            done_q;
    logic [7:0]      rd_q;
    logic [DB_W-1:0] lo_q;     // second chunk, only meaningful in 4-bit mode
    logic            cnt_load;
    logic [3:0]      cnt_val;
    logic            expired;

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_data = rd_q;

    lcd_tick_cnt u_tick (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .load    (cnt_load),
        .value   (cnt_val),
        .expired (expired)
    );

    // Reload the tick counter on every timed-phase entry.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = 4'(T_SETUP);
        case (state_q)
            ST_IDLE:  cnt_load = bus.start;
            ST_SETUP: begin cnt_load = expired; cnt_val = 4'(T_EHIGH); end
            ST_EHIGH: begin cnt_load = expired; cnt_val = 4'(T_HOLD);  end
            ST_HOLD:  cnt_load = expired && (DB_W == 4) && !nib_q;
            default:  ;
        endcase
    end

    // Cycle sequencer; all pin and handshake outputs are registered here.
    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            nib_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 8'h00;
            lo_q    <= '0;
            E_out   <= 1'b0;
            RS_out  <= 1'b0;
            RW_out  <= 1'b0;
            db_out  <= '0;
            db_oe   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    state_q <= ST_SETUP;
                    busy_q  <= 1'b1;
                    nib_q   <= 1'b0;
                    RS_out  <= bus.rs_in;
                    RW_out  <= bus.rw_in;
                    db_oe   <= ~bus.rw_in;
                    db_out  <= bus.data_in[7 -: DB_W];   // full byte or high nibble
                    lo_q    <= bus.data_in[DB_W-1:0];
                end
                ST_SETUP: if (expired) begin
                    state_q <= ST_EHIGH;
                    E_out   <= 1'b1;
                end
                ST_EHIGH: if (expired) begin
                    state_q <= ST_HOLD;
                    E_out   <= 1'b0;
                    if (RW_out == LCD_RD) begin
                        if (DB_W == 8)   rd_q      <= 8'(db_in);
                        else if (!nib_q) rd_q[7:4] <= db_in[3:0];
                        else             rd_q[3:0] <= db_in[3:0];
                    end
                end
                ST_HOLD: if (expired) begin
                    if ((DB_W == 4) && !nib_q) begin
                        state_q <= ST_SETUP;
                        nib_q   <= 1'b1;
                        db_out  <= lo_q;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        db_oe   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_bus_cycle.sv
// Bench for lcd_bus_cycle: an 8-bit default instance and a 4-bit, T_EHIGH=3
// instance share one request stream; a cycle-indexed reference model predicts
// every output of both each cycle, plus directed table and corner sequences.
module tb_lcd_bus_cycle;
    localparam int P4 = 1 + 3 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, rs = 1'b0, rw = 1'b0, hi4 = 1'b0;
    logic [7:0] data = 8'h00, rd_byte = 8'h00;

    lcd_bus_cycle_if if8();
    lcd_bus_cycle_if if4();
    assign if8.start = start;  assign if8.rs_in = rs;  assign if8.rw_in = rw;  assign if8.data_in = data;
    assign if4.start = start;  assign if4.rs_in = rs;  assign if4.rw_in = rw;  assign if4.data_in = data;

    logic       e8, rs8, rw8, oe8, e4, rs4, rw4, oe4;
    logic [7:0] db8, din8;
    logic [3:0] db4, din4;
    assign din8 = rd_byte;
    assign din4 = hi4 ? rd_byte[7:4] : rd_byte[3:0];

    lcd_bus_cycle u8 (.clk_1ms(clk), .reset(rst_n), .bus(if8), .E_out(e8), .RS_out(rs8),
                      .RW_out(rw8), .db_out(db8), .db_oe(oe8), .db_in(din8));
    lcd_bus_cycle #(.DB_W(4), .T_SETUP(1), .T_EHIGH(3), .T_HOLD(1))
        u4 (.clk_1ms(clk), .reset(rst_n), .bus(if4), .E_out(e4), .RS_out(rs4),
            .RW_out(rw4), .db_out(db4), .db_oe(oe4), .db_in(din4));

    // Reference model: t = cycle number since acceptance (1 = first SETUP cycle).
    typedef struct {
        bit         active;
        int         t;
        logic       rs, rw;
        logic [7:0] data, rd;
    } mdl_t;

    mdl_t m8 = '{default: 0};
    mdl_t m4 = '{default: 0};
    int errors = 0, checks = 0;

    function automatic mdl_t mstep(mdl_t m, logic st, logic r_s, logic r_w, logic [7:0] d,
                                   logic [7:0] din, int dbw, int ts, int te, int th);
        int p, n, k, off;
        p = ts + te + th;
        n = (dbw == 4) ? 2 : 1;
        if (m.active) begin
            if (m.t == n * p + 1) m.active = 0;
            else begin
                k = (m.t - 1) / p;
                off = (m.t - 1) % p;
                if (m.rw && off == ts + te - 1) begin
                    if (n == 1)      m.rd      = din;
                    else if (k == 0) m.rd[7:4] = din[3:0];
                    else             m.rd[3:0] = din[3:0];
                end
                m.t = m.t + 1;
            end
        end else if (st) begin
            m.active = 1; m.t = 1; m.rs = r_s; m.rw = r_w; m.data = d;
        end
        return m;
    endfunction

    // Expected {E, RS, RW, db(8), oe, done, busy, rd_data} for the model's current cycle.
    function automatic logic [21:0] mexp(mdl_t m, int dbw, int ts, int te, int th);
        int p, n, k, off;
        logic e, oe, dn;
        logic [7:0] db;
        p = ts + te + th;
        n = (dbw == 4) ? 2 : 1;
        e = 0; oe = 0; dn = 0;
        db = (n == 2) ? {4'h0, m.data[3:0]} : m.data;
        if (m.active && m.t == n * p + 1) dn = 1;
        else if (m.active) begin
            k = (m.t - 1) / p;
            off = (m.t - 1) % p;
            e = (off >= ts) && (off < ts + te);
            oe = ~m.rw;
            if (n == 2 && k == 0) db = {4'h0, m.data[7:4]};
        end
        return {e, m.rs, m.rw, db, oe, dn, logic'(m.active), m.rd};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8 <= '{default: 0};
            m4 <= '{default: 0};
        end else begin
            m8 <= mstep(m8, start, rs, rw, data, din8, 8, 1, 2, 1);
            m4 <= mstep(m4, start, rs, rw, data, {4'h0, din4}, 4, 1, 3, 1);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("trace8", 32'({e8, rs8, rw8, db8, oe8, if8.done, if8.busy, if8.rd_data}),
              32'(mexp(m8, 8, 1, 2, 1)));
        check("trace4", 32'({e4, rs4, rw4, 4'h0, db4, oe4, if4.done, if4.busy, if4.rd_data}),
              32'(mexp(m4, 4, 1, 3, 1)));
        hi4 = m4.active && (m4.t <= P4);
    end

    typedef struct {
        logic       rs, rw;
        logic [7:0] data, dbin, rd8, rd4;
        int         lat8, lat4;
    } vec_t;
    vec_t tbl[5];

    // One request; returns the done cycle (1 = first SETUP cycle) and rd_data at done.
    task automatic run_txn(input logic r_s, input logic r_w, input logic [7:0] d,
                           input logic [7:0] dbin, output int l8, output int l4,
                           output logic [7:0] r8, output logic [7:0] r4);
        @(negedge clk);
        rs = r_s; rw = r_w; data = d; rd_byte = dbin; start = 1'b1;
        l8 = -1; l4 = -1; r8 = 8'hxx; r4 = 8'hxx;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (if8.done && l8 < 0) begin l8 = c; r8 = if8.rd_data; end
            if (if4.done && l4 < 0) begin l4 = c; r4 = if4.rd_data; end
            if (l8 >= 0 && l4 >= 0) break;
        end
    endtask

    initial begin
        int l8, l4, d8a, d8b, d4a, d4b;
        logic [7:0] r8, r4;
        tbl[0] = '{1'b1, 1'b0, 8'h48, 8'h00, 8'h00, 8'h00, 5, 11};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h80, 8'h80, 8'h80, 5, 11};
        tbl[2] = '{1'b1, 1'b0, 8'hA5, 8'hFF, 8'h80, 8'h80, 5, 11};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h3C, 8'h3C, 8'h3C, 5, 11};
        tbl[4] = '{1'b1, 1'b1, 8'h11, 8'hC3, 8'hC3, 8'hC3, 5, 11};

        repeat (3) @(negedge clk);
        check("reset8", 32'({e8, rs8, rw8, db8, oe8, if8.done, if8.busy, if8.rd_data}), 32'h0);
        check("reset4", 32'({e4, rs4, rw4, db4, oe4, if4.done, if4.busy, if4.rd_data}), 32'h0);
        #2 rst_n = 1'b1;

        // Directed table; the first start is sampled on the first edge after release.
        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i].rs, tbl[i].rw, tbl[i].data, tbl[i].dbin, l8, l4, r8, r4);
            check("lat8", 32'(l8), 32'(tbl[i].lat8));
            check("lat4", 32'(l4), 32'(tbl[i].lat4));
            check("rd8", 32'(r8), 32'(tbl[i].rd8));
            check("rd4", 32'(r4), 32'(tbl[i].rd4));
        end

        // start held high: one IDLE cycle between transactions.
        @(negedge clk);
        rs = 1'b0; rw = 1'b0; data = 8'h5A; start = 1'b1;
        d8a = -1; d8b = -1; d4a = -1; d4b = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (if8.done) begin if (d8a < 0) d8a = c; else if (d8b < 0) d8b = c; end
            if (if4.done) begin if (d4a < 0) d4a = c; else if (d4b < 0) d4b = c; end
        end
        start = 1'b0;
        check("b2b8", 32'(d8b - d8a), 32'd6);
        check("b2b4", 32'(d4b - d4a), 32'd12);
        repeat (14) @(negedge clk);

        // start pulse during DONE is ignored.
        @(negedge clk);
        rw = 1'b0; data = 8'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 10 && !if8.done; c++) @(negedge clk);
        check("done8_seen", 32'(if8.done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_done_a", 32'(if8.busy), 32'd0);
        @(negedge clk);
        check("ign_done_b", 32'(if8.busy), 32'd0);
        repeat (12) @(negedge clk);

        // Reset during the second EHIGH cycle of a read.
        @(negedge clk);
        rs = 1'b0; rw = 1'b1; data = 8'h00; rd_byte = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ehigh8", 32'(e8), 32'd1);
        check("ehigh4", 32'(e4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst8", 32'({e8, if8.busy, oe8, if8.rd_data}), 32'h0);
        check("midrst4", 32'({e4, if4.busy, oe4, if4.rd_data}), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_txn(1'b1, 1'b0, 8'hC7, 8'hFF, l8, l4, r8, r4);
        check("post_lat8", 32'(l8), 32'd5);
        check("post_lat4", 32'(l4), 32'd11);
        check("post_rd8", 32'(r8), 32'h00);
        check("post_rd4", 32'(r4), 32'h00);

        // Random requests, start only sometimes, random pad data every cycle.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            rs = 1'($urandom);
            rw = 1'($urandom);
            data = 8'($urandom);
            rd_byte = 8'($urandom);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcd_bus_cycle.md
# lcd_bus_cycle

Parametrised HD44780 bus-cycle engine; successor to the fixed 8-bit write-only cycle. Executes one complete LCD bus transaction per `start` request: write or read (busy-flag/data read), 8-bit or 4-bit interface, with programmable setup, E-high and hold durations counted in `clk_1ms` cycles. Sits between the LCD command sequencer (init/clear/print FSM) and the module pins.

## Interface
- `DB_W`, default 8: data-bus width at the pins; legal values 8 or 4. With 4, a byte moves as two nibbles, high nibble first.
- `T_SETUP`, default 1: cycles RS/RW/data are stable before E rises; legal range 1..15.
- `T_EHIGH`, default 2: cycles E is held high per nibble or byte; legal range 1..15.
- `T_HOLD`, default 1: cycles after E falls before the bus changes or is released; legal range 1..15.

- `clk_1ms` in 1: the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a transaction; sampled only in IDLE.
- `rs_in` in 1: register select for the request.
- `rw_in` in 1: 0 = write, 1 = read.
- `data_in` in 8: write byte.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when the transaction completes.
- `rd_data` out 8: byte captured by the last read; holds until the next read completes.
- `E_out` out 1: LCD enable.
- `RS_out` out 1: LCD RS.
- `RW_out` out 1: LCD R/W.
- `db_out` out DB_W: driven data.
- `db_oe` out 1: pad output enable for `db_out`.
- `db_in` in DB_W: pad input data.

## Operation
- States: IDLE, SETUP, EHIGH, HOLD, DONE. A nibble flag `nib` is used only when DB_W = 4.
- **IDLE, with `start` = 1:**
  - Latch `rs_in`, `rw_in` and `data_in`.
  - Load the counter with T_SETUP and clear `nib`.
  - Go to SETUP.
- **SETUP:**
  - `E_out` = 0.
  - RS/RW are driven from the latched values.
  - `db_out` carries the current byte or nibble. `db_oe` = not latched RW.
  - When the counter expires, load T_EHIGH and go to EHIGH.
- **EHIGH:**
  - `E_out` = 1.
  - For a read, `db_in` is sampled on the last EHIGH cycle: into `rd_data[7:0]` (8-bit), `rd_data[7:4]` (nibble 0) or `rd_data[3:0]` (nibble 1).
  - When the counter expires, load T_HOLD and go to HOLD.
- **HOLD:**
  - `E_out` = 0; the bus is unchanged.
  - When the counter expires:
    - DB_W = 4 and `nib` = 0: set `nib`, load T_SETUP, go to SETUP.
    - Otherwise: go to DONE.
- **DONE:**
  - `done` = 1 for exactly one cycle, then IDLE.
  - `start` asserted during DONE is ignored and is not queued.
- `start` outside IDLE is ignored; the latched request is never modified mid-transaction.
- `db_oe` = 0 in IDLE and DONE (bus released).
- RS_out and RW_out hold the last latched values in IDLE.
- `db_out` holds its last value when `db_oe` = 0.
- A write never changes `rd_data`.

## Timing
- `busy` rises in the cycle after `start` is sampled.
- Latency from the `start` sampling edge to `done` high:
  - DB_W = 8: T_SETUP+T_EHIGH+T_HOLD+1 cycles; 5 with the defaults.
  - DB_W = 4: 2·(T_SETUP+T_EHIGH+T_HOLD)+1 cycles; 9 with the defaults.
- `busy` falls together with `done`.
- Earliest back-to-back: `start` seen the cycle after `done` is accepted, giving one IDLE cycle between transactions.
- Read data is valid on `rd_data` in the same cycle as `done`.
- All outputs are registered or decoded from registered state only; no combinational path from `start`.
- The counter is 4 bits and counts down to 1; a parameter value of N gives exactly N cycles in that state.
- **Reset (asynchronous, `reset` = 0) at any point, including mid-transaction:**
  - State goes to IDLE.
  - `E_out`, `RS_out`, `RW_out`, `db_oe`, `done` and `busy` are forced to 0.
  - `db_out` and `rd_data` are forced to 0.
  - `nib` is cleared.
  - An E pulse in progress is truncated immediately.
- **Reset release:** the first `start` can be sampled on the first rising edge after `reset` goes high.

## Structure
- Shared package `lcd_pkg`:
  - State encoding: IDLE=0, SETUP=1, EHIGH=2, HOLD=3, DONE=4.
  - RW constants: LCD_WR=0, LCD_RD=1.
  - Constants: LCD_BUSY_BIT=7, timing limit T_MAX=15.
  - Reused by the sequencer.
- One natural sub-module: `lcd_tick_cnt`, a loadable 4-bit down-counter with `load`, `value` and `expired` ports, shared by all three timed states.
- Elaboration-time checks: DB_W must be 4 or 8, and each T_* must be in 1..15.

## Test plan
- **8-bit write:** defaults, rs_in=1, data_in=0x48, one start pulse -> `db_out`=0x48 with `db_oe`=1 and RS_out=1 from SETUP. `E_out` high for exactly 2 cycles. `done` pulses 5 cycles after start. `rd_data` stays unchanged.
- **8-bit busy read:** rw_in=1, rs_in=0, db_in=0x80 during EHIGH -> `db_oe`=0 throughout. `rd_data`=0x80 when `done` pulses. RW_out=1.
- **4-bit write:** DB_W=4, T_EHIGH=3, data_in=0xA5 -> `db_out`=0xA, then 0x5. Two E pulses of 3 cycles each. `done` at cycle 2·(1+3+1)+1=11.
- **4-bit read:** DB_W=4, db_in=0x3 during the first E pulse and 0xC during the second -> `rd_data`=0x3C.
- **Start handling:** `start` held high continuously -> transactions are separated by exactly one IDLE cycle. A `start` pulse asserted during DONE produces no extra transaction.
- **Reset mid-operation:** `reset` low during the 2nd EHIGH cycle -> `E_out`, `busy`, `db_oe` and `rd_data` are 0 immediately. After release, a new start yields a full-length, correct transaction.
